alu_nzcv_arb: RTL

- Two-requester round-robin arbiter and sequencer for one shared alu_nzcv instance.
- Each requester presents operands and an ALU opcode on a valid/ready channel.
- The granted operation executes in the accept cycle. Its result, NZCV flags and requester ID are registered into a single-entry response buffer drained through a valid/ready response channel.
- Sits between issue logic (two ports) and writeback/flags consumers.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_nzcv.sv | 45 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_nzcv_arb.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the alu_nzcv_arb slice: ALU opcodes, NZCV flag bit positions
// and the response buffer state.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_nzcv.sv
// Combinational N-bit ALU (ADD/SUB/AND/OR) producing NZCV flags.
// SUB is a + ~b + 1, so C is the no-borrow carry.
module alu_nzcv
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  alu_ctrl_e    i_ctrl,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_nzcv
);

    logic [N-1:0] b_op;
    logic         cin;
    logic [N:0]   sum;
    logic         carry;
    logic         ovf;

    always_comb begin
        b_op     = (i_ctrl == ALU_SUB) ? ~i_b : i_b;
        cin      = (i_ctrl == ALU_SUB);
        sum      = {1'b0, i_a} + {1'b0, b_op} + {{N{1'b0}}, cin};
        o_result = sum[N-1:0];
        carry    = 1'b0;
        ovf      = 1'b0;
        case (i_ctrl)
            ALU_ADD, ALU_SUB: begin
                carry = sum[N];
                // Signed overflow: both addends agree in sign but the sum does not.
                ovf   = (i_a[N-1] == b_op[N-1]) && (sum[N-1] != i_a[N-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            default: ;
        endcase
        o_nzcv         = '0;
        o_nzcv[NZCV_N] = o_result[N-1];
        o_nzcv[NZCV_Z] = (o_result == '0);
        o_nzcv[NZCV_C] = carry;
        o_nzcv[NZCV_V] = ovf;
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. last_grant resets to 1 so requester 0 wins
// the first conflict; it only moves when a grant is actually issued.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic last_grant;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = last_grant ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
        end else if (|o_gnt) begin
            last_grant <= o_gnt[1];
        end
    end

endmodule

// File: rtl/alu_nzcv_arb.sv
// Two-requester round-robin front end for a shared alu_nzcv with a one-entry
// response buffer. Optional architectural flags register: ALU_FLAGS_REG_EN.
module alu_nzcv_arb
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid0,
    output logic         o_ready0,
    input  logic [N-1:0] i_a0,
    input  logic [N-1:0] i_b0,
    input  alu_ctrl_e    i_ctrl0,
    input  logic         i_valid1,
    output logic         o_ready1,
    input  logic [N-1:0] i_a1,
    input  logic [N-1:0] i_b1,
    input  alu_ctrl_e    i_ctrl1,
`ifdef ALU_FLAGS_REG_EN
    input  logic         i_set_flags0,
    input  logic         i_set_flags1,
    output logic [3:0]   o_flags,
`endif
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [N-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_nzcv,
    output logic         o_rsp_id
);

    rsp_state_e   state;
    rsp_state_e   state_next;
    logic         can_accept;
    logic [1:0]   gnt;
    logic         accept;
    logic         sel;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    alu_ctrl_e    alu_ctrl;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    // Gating with reset keeps both readies low while reset is asserted.
    assign can_accept = (state == RSP_EMPTY) | i_rsp_ready;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({i_valid1, i_valid0}),
        .i_en    (can_accept & i_rst_n),
        .o_gnt   (gnt)
    );

    assign accept   = |gnt;
    assign sel      = gnt[1];
    assign o_ready0 = gnt[0];
    assign o_ready1 = gnt[1];

    assign alu_a    = sel ? i_a1 : i_a0;
    assign alu_b    = sel ? i_b1 : i_b0;
    assign alu_ctrl = sel ? i_ctrl1 : i_ctrl0;

    alu_nzcv #(.N(N)) u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_ctrl   (alu_ctrl),
        .o_result (alu_result),
        .o_nzcv   (alu_flags)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RSP_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A drain and a new accept on the same edge keep the buffer full.
    always_comb begin
        state_next = state;
        case (state)
            RSP_EMPTY: if (accept) state_next = RSP_FULL;
            RSP_FULL:  if (i_rsp_ready && !accept) state_next = RSP_EMPTY;
            default:   state_next = RSP_EMPTY;
        endcase
    end

    assign o_rsp_valid = (state == RSP_FULL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_result <= '0;
            o_rsp_nzcv   <= '0;
            o_rsp_id     <= 1'b0;
        end else if (accept) begin
            o_rsp_result <= alu_result;
            o_rsp_nzcv   <= alu_flags;
            o_rsp_id     <= sel;
        end
    end

`ifdef ALU_FLAGS_REG_EN
    logic set_sel;
    assign set_sel = sel ? i_set_flags1 : i_set_flags0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_flags <= '0;
        end else if (accept && set_sel) begin
            o_flags <= alu_flags;
        end
    end
`endif

endmodule
